// File: rtl/data_memory_mc_if.sv
// Request/response bundle between the core and the multi-cycle data memory.
interface data_memory_mc_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_mc.sv
// Multi-cycle RV32 data memory (B/H/W loads and stores); rsp_valid pulses LATENCY edges after accept.
// req_ready only in IDLE, so one transaction per LATENCY+1 cycles; the response cannot be stalled.
module data_memory_mc #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  data_memory_mc_if.slave bus
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1) begin : g_latency_chk
    $error("data_memory_mc: LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  logic [XLEN-1:0] memory [0:DEPTH_WORDS-1];

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic            err_q;

  logic            req_ready, accept, latch, commit;
  logic            cur_we;
  logic [2:0]      cur_f3;
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic            illegal, misaligned, out_of_range, err;
  logic [XLEN-1:0] rd_word, rd_shift, load_val, rsp_now, st_data;
  logic [3:0]      st_be;

  assign req_ready     = reset && (state_q == S_IDLE);
  assign accept        = bus.req_valid && req_ready;
  assign bus.req_ready = req_ready;

  // In IDLE the decode sees the live request so a LATENCY=1 store can commit on its accept edge.
  assign cur_we    = (state_q == S_IDLE) ? bus.req_we     : we_q;
  assign cur_f3    = (state_q == S_IDLE) ? bus.req_funct3 : f3_q;
  assign cur_addr  = (state_q == S_IDLE) ? bus.req_addr   : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? bus.req_wdata  : wdata_q;

  assign illegal      = (cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11) || (cur_we && cur_f3[2]);
  assign misaligned   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                        ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
  assign out_of_range = {2'b00, cur_addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS);
  assign err          = illegal || misaligned || out_of_range;

  assign rd_word  = memory[cur_addr[AW+1:2]];
  assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    load_val = '0;
    case (cur_f3)
      3'b000:  load_val = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: load_val = '0;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick which lanes land.
  always_comb begin
    st_be   = 4'b1111;
    st_data = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << cur_addr[1:0];
        st_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cur_wdata[15:0]}};
      end
      default: st_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          latch   = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = reset && cur_we && !err && (state_d == S_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == S_RESP) begin
        rdata_q <= rsp_now;
        err_q   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) memory[cur_addr[AW+1:2]][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign rsp_now       = (err || cur_we) ? '0 : load_val;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = bus.rsp_valid ? rsp_now : rdata_q;
  assign bus.rsp_err   = bus.rsp_valid ? err : err_q;
endmodule

// File: tb/tb_data_memory_mc.sv
// Randomized bench for data_memory_mc against a byte-array reference model, plus throughput runs at LATENCY 1/2/4.
module tb_data_memory_mc;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk;
  logic reset;

  data_memory_mc_if #(.XLEN(32)) dif2 ();
  data_memory_mc_if #(.XLEN(32)) dif1 ();
  data_memory_mc_if #(.XLEN(32)) dif4 ();

  data_memory_mc #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (.clk(clk), .reset(reset), .bus(dif2));
  data_memory_mc #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(1))   u_dut1 (.clk(clk), .reset(reset), .bus(dif1));
  data_memory_mc #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(4))   u_dut4 (.clk(clk), .reset(reset), .bus(dif4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] mdl_mem [0:4*DEPTH-1];
  logic [31:0] rd;
  logic        er;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: memory as a flat byte array, little-endian.
  task automatic ref_txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] r);
    int sz;
    logic [31:0] v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e = 1'b0;
    r = '0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) e = 1'b1;
    if (we && f3[2]) e = 1'b1;
    if ((a % 32'(sz)) != 0) e = 1'b1;
    if ((a >> 2) >= 32'(DEPTH)) e = 1'b1;
    if (e) return;
    if (we) begin
      for (int i = 0; i < sz; i++) mdl_mem[a + 32'(i)] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(mdl_mem[a + 32'(i)]) << (8*i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      r = v;
    end
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got_rd, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd;
    int w;
    int edges;
    w = 0;
    while (!dif2.req_ready && w < 20) begin step(); w++; end
    chk("ready_timeout", 32'(w < 20), 32'd1);
    dif2.req_valid  = 1'b1;
    dif2.req_we     = we;
    dif2.req_funct3 = f3;
    dif2.req_addr   = a;
    dif2.req_wdata  = wd;
    step();
    dif2.req_valid  = 1'b0;
    dif2.req_we     = 1'($urandom);
    dif2.req_funct3 = 3'($urandom);
    dif2.req_addr   = $urandom;
    dif2.req_wdata  = $urandom;
    ref_txn(we, f3, a, wd, exp_err, exp_rd);
    edges = 1;
    while (!dif2.rsp_valid && edges < 20) begin step(); edges++; end
    chk("rsp_latency", 32'(edges), 32'(LAT));
    got_rd  = dif2.rsp_rdata;
    got_err = dif2.rsp_err;
    chk("rsp_rdata", got_rd, exp_rd);
    chk("rsp_err", 32'(got_err), 32'(exp_err));
    step();
    chk("rsp_width", 32'(dif2.rsp_valid), 32'd0);
    chk("rsp_hold", dif2.rsp_rdata, got_rd);
  endtask

  function automatic logic get_rdy(input int k);
    case (k)
      1:       return dif1.req_ready;
      4:       return dif4.req_ready;
      default: return dif2.req_ready;
    endcase
  endfunction

  function automatic logic get_vld(input int k);
    case (k)
      1:       return dif1.rsp_valid;
      4:       return dif4.rsp_valid;
      default: return dif2.rsp_valid;
    endcase
  endfunction

  task automatic set_valid(input int k, input logic v);
    case (k)
      1:       dif1.req_valid = v;
      4:       dif4.req_valid = v;
      default: dif2.req_valid = v;
    endcase
  endtask

  // With req_valid held high: ready on every (L+1)-th sample, response L samples after each accept.
  task automatic tput(input int k);
    int n_acc;
    int n_rsp;
    int total;
    logic r;
    logic v;
    n_acc = 0;
    n_rsp = 0;
    total = 6 * (k + 1);
    set_valid(k, 1'b1);
    for (int n = 0; n < total; n++) begin
      r = get_rdy(k);
      v = get_vld(k);
      chk($sformatf("tput%0d_ready", k), 32'(r), 32'(n % (k + 1) == 0));
      chk($sformatf("tput%0d_rsp", k), 32'(v), 32'(n % (k + 1) == k));
      if (r) n_acc++;
      if (v) n_rsp++;
      if (n == total - 1) set_valid(k, 1'b0);
      step();
    end
    chk($sformatf("tput%0d_count", k), 32'(n_rsp), 32'(n_acc));
  endtask

  logic [2:0]  d2_f3 [5] = '{3'b100, 3'b000, 3'b101, 3'b001, 3'b000};
  logic [31:0] d2_a  [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
  logic [31:0] d2_e  [5] = '{32'h0000_00DE, 32'hFFFF_FFDE, 32'h0000_DEAD, 32'hFFFF_DEAD, 32'hFFFF_FFEF};
  logic [2:0]  legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] old10;
    bit          saw_rsp;

    reset = 1'b0;
    dif2.req_valid = 1'b0; dif2.req_we = 1'b0; dif2.req_funct3 = 3'b010; dif2.req_addr = '0; dif2.req_wdata = '0;
    dif1.req_valid = 1'b0; dif1.req_we = 1'b0; dif1.req_funct3 = 3'b010; dif1.req_addr = '0; dif1.req_wdata = '0;
    dif4.req_valid = 1'b0; dif4.req_we = 1'b0; dif4.req_funct3 = 3'b010; dif4.req_addr = '0; dif4.req_wdata = '0;
    step();
    step();
    chk("reset_ready", 32'(dif2.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(dif2.rsp_valid), 32'd0);
    chk("reset_rdata", dif2.rsp_rdata, 32'd0);
    chk("reset_err", 32'(dif2.rsp_err), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_ready", 32'(dif2.req_ready), 32'd1);

    for (int i = 0; i < 16; i++) do_txn(1'b1, 3'b010, 32'(4 * i), $urandom, rd, er);

    do_txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er);
    chk("sw_err", 32'(er), 32'd0);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b0, d2_f3[i], d2_a[i], 32'h0, rd, er);
      chk($sformatf("subword_load%0d", i), rd, d2_e[i]);
    end
    do_txn(1'b1, 3'b000, 32'h11, 32'hAAAA_AA7F, rd, er);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("sb_merge", rd, 32'hDEAD_7FEF);
    do_txn(1'b1, 3'b001, 32'h12, 32'h5555_1234, rd, er);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("sh_merge", rd, 32'h1234_7FEF);

    do_txn(1'b0, 3'b010, 32'h11, 32'h0, rd, er);
    chk("lw_misaligned_err", 32'(er), 32'd1);
    chk("lw_misaligned_rdata", rd, 32'd0);
    do_txn(1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF, rd, er);
    chk("sh_misaligned_err", 32'(er), 32'd1);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("sh_misaligned_nowrite", rd, 32'h1234_7FEF);
    do_txn(1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    do_txn(1'b0, 3'b011, 32'h10, 32'h0, rd, er);
    chk("illegal_f3_err", 32'(er), 32'd1);

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      f3 = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom);
      a  = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 63));
      do_txn(we, f3, a, $urandom, rd, er);
    end

    do_txn(1'b0, 3'b010, 32'h10, 32'h0, old10, er);
    dif2.req_valid  = 1'b1;
    dif2.req_we     = 1'b1;
    dif2.req_funct3 = 3'b010;
    dif2.req_addr   = 32'h10;
    dif2.req_wdata  = 32'h0;
    step();
    dif2.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    saw_rsp = 1'b0;
    chk("rst_busy_rdata", dif2.rsp_rdata, 32'd0);
    chk("rst_busy_err", 32'(dif2.rsp_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (dif2.rsp_valid) saw_rsp = 1'b1;
      chk("rst_busy_ready", 32'(dif2.req_ready), 32'd0);
      step();
    end
    chk("rst_busy_no_rsp", 32'(saw_rsp), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_release_ready", 32'(dif2.req_ready), 32'd1);
    step();
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("rst_store_dropped", rd, old10);

    dif2.req_we = 1'b0; dif2.req_funct3 = 3'b010; dif2.req_addr = 32'h20;
    tput(1);
    tput(2);
    tput(4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
